// File: rtl/rrefs.sv
// 5x5 Q16.16 matrix inverter: Gauss-Jordan on [A | I] with partial pivoting, one row per cycle.
// Latency start->done is 276 cycles when A is nonsingular; writes and start are ignored while busy.
module rrefs #(
  parameter int FRAC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        singular,
  output logic [31:0] inv11, output logic [31:0] inv12, output logic [31:0] inv13,
  output logic [31:0] inv14, output logic [31:0] inv15,
  output logic [31:0] inv21, output logic [31:0] inv22, output logic [31:0] inv23,
  output logic [31:0] inv24, output logic [31:0] inv25,
  output logic [31:0] inv31, output logic [31:0] inv32, output logic [31:0] inv33,
  output logic [31:0] inv34, output logic [31:0] inv35,
  output logic [31:0] inv41, output logic [31:0] inv42, output logic [31:0] inv43,
  output logic [31:0] inv44, output logic [31:0] inv45,
  output logic [31:0] inv51, output logic [31:0] inv52, output logic [31:0] inv53,
  output logic [31:0] inv54, output logic [31:0] inv55
);

  localparam int QW = 32 + FRAC;
  localparam logic [31:0]   ONE      = 32'(1) << FRAC;
  localparam logic [QW-1:0] NUM_INIT = QW'(1) << (2 * FRAC);

  typedef enum logic [2:0] {
    S_IDLE, S_PIVOT, S_SWAP, S_RECIP, S_NORM, S_ELIM, S_FINISH
  } state_t;

  state_t             state_q;
  logic [31:0]        a_q   [25];
  logic signed [31:0] m_q   [5][5];
  logic signed [31:0] w_q   [5][5];
  logic [31:0]        inv_q [5][5];
  logic               busy_q, done_q, sing_q;
  logic [2:0]         k_q, p_q;
  logic [5:0]         cnt_q;
  logic [1:0]         e_q;
  logic [QW-1:0]      num_q;
  logic [31:0]        rem_q;
  logic [32:0]        den_q;
  logic               neg_q;

  function automatic logic [32:0] mag33(input logic signed [31:0] x);
    logic [32:0] e;
    e = {x[31], x};
    return x[31] ? (33'd0 - e) : e;
  endfunction

  // Q-format multiply: full 64-bit signed product, arithmetic shift, wrap to 32 bits.
  function automatic logic signed [31:0] mulq(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    return 32'((64'(a) * 64'(b)) >>> FRAC);
  endfunction

  logic [2:0]  piv_idx_d;
  logic [32:0] piv_mag_d;
  always_comb begin
    piv_idx_d = k_q;
    piv_mag_d = '0;
    for (int i = 0; i < 5; i++) begin
      if (3'(i) >= k_q && mag33(m_q[i][k_q]) > piv_mag_d) begin
        piv_idx_d = 3'(i);
        piv_mag_d = mag33(m_q[i][k_q]);
      end
    end
  end

  // Restoring divider step; remainder always stays below the 32-bit divisor magnitude.
  logic [32:0]        rem_sh_d;
  logic               qbit_d;
  logic [31:0]        rem_d;
  logic signed [31:0] recip_d;
  logic [2:0]         erow_d;
  always_comb begin
    rem_sh_d = {rem_q, num_q[QW-1]};
    qbit_d   = (rem_sh_d >= den_q);
    rem_d    = qbit_d ? (rem_sh_d[31:0] - den_q[31:0]) : rem_sh_d[31:0];
    recip_d  = neg_q ? -num_q[31:0] : num_q[31:0];
    erow_d   = (3'(e_q) < k_q) ? 3'(e_q) : 3'(e_q) + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sing_q  <= 1'b0;
      k_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      e_q     <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      neg_q   <= 1'b0;
      for (int i = 0; i < 25; i++) a_q[i] <= '0;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          m_q[i][j]   <= '0;
          w_q[i][j]   <= '0;
          inv_q[i][j] <= '0;
        end
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (done_q) busy_q <= 1'b0;
          if (!busy_q) begin
            if (wr_en && wr_addr < 5'd25) a_q[wr_addr] <= wr_data;
            if (start) begin
              for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                  m_q[i][j] <= a_q[i*5+j];
                  w_q[i][j] <= (i == j) ? ONE : '0;
                end
              end
              busy_q  <= 1'b1;
              sing_q  <= 1'b0;
              k_q     <= '0;
              state_q <= S_PIVOT;
            end
          end
        end
        S_PIVOT: begin
          if (piv_mag_d == '0) begin
            sing_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            p_q     <= piv_idx_d;
            state_q <= S_SWAP;
          end
        end
        S_SWAP: begin
          for (int j = 0; j < 5; j++) begin
            m_q[k_q][j] <= m_q[p_q][j];
            m_q[p_q][j] <= m_q[k_q][j];
            w_q[k_q][j] <= w_q[p_q][j];
            w_q[p_q][j] <= w_q[k_q][j];
          end
          den_q   <= mag33(m_q[p_q][k_q]);
          neg_q   <= m_q[p_q][k_q][31];
          rem_q   <= '0;
          num_q   <= NUM_INIT;
          cnt_q   <= '0;
          state_q <= S_RECIP;
        end
        S_RECIP: begin
          num_q <= {num_q[QW-2:0], qbit_d};
          rem_q <= rem_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(QW - 1)) state_q <= S_NORM;
        end
        S_NORM: begin
          for (int j = 0; j < 5; j++) begin
            m_q[k_q][j] <= mulq(m_q[k_q][j], recip_d);
            w_q[k_q][j] <= mulq(w_q[k_q][j], recip_d);
          end
          m_q[k_q][k_q] <= ONE;
          e_q     <= '0;
          state_q <= S_ELIM;
        end
        S_ELIM: begin
          for (int j = 0; j < 5; j++) begin
            m_q[erow_d][j] <= m_q[erow_d][j] - mulq(m_q[erow_d][k_q], m_q[k_q][j]);
            w_q[erow_d][j] <= w_q[erow_d][j] - mulq(m_q[erow_d][k_q], w_q[k_q][j]);
          end
          m_q[erow_d][k_q] <= '0;
          e_q <= e_q + 2'd1;
          if (e_q == 2'd3) begin
            if (k_q == 3'd4) begin
              state_q <= S_FINISH;
            end else begin
              k_q     <= k_q + 3'd1;
              state_q <= S_PIVOT;
            end
          end
        end
        S_FINISH: begin
          if (!sing_q) begin
            for (int i = 0; i < 5; i++) begin
              for (int j = 0; j < 5; j++) inv_q[i][j] <= w_q[i][j];
            end
          end
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign singular = sing_q;

  assign inv11 = inv_q[0][0]; assign inv12 = inv_q[0][1]; assign inv13 = inv_q[0][2];
  assign inv14 = inv_q[0][3]; assign inv15 = inv_q[0][4];
  assign inv21 = inv_q[1][0]; assign inv22 = inv_q[1][1]; assign inv23 = inv_q[1][2];
  assign inv24 = inv_q[1][3]; assign inv25 = inv_q[1][4];
  assign inv31 = inv_q[2][0]; assign inv32 = inv_q[2][1]; assign inv33 = inv_q[2][2];
  assign inv34 = inv_q[2][3]; assign inv35 = inv_q[2][4];
  assign inv41 = inv_q[3][0]; assign inv42 = inv_q[3][1]; assign inv43 = inv_q[3][2];
  assign inv44 = inv_q[3][3]; assign inv45 = inv_q[3][4];
  assign inv51 = inv_q[4][0]; assign inv52 = inv_q[4][1]; assign inv53 = inv_q[4][2];
  assign inv54 = inv_q[4][3]; assign inv55 = inv_q[4][4];

endmodule

// File: tb/tb_rrefs.sv
// Scoreboard bench for rrefs: expected inverses queued at start, checked at done.
module tb_rrefs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic        busy, done, singular;
  logic [31:0] inv [25];

  always #5 clk = ~clk;

  typedef logic [24:0][31:0] mat_t;
  typedef struct packed {
    mat_t        inv;
    logic        sing;
    logic [15:0] lat;
    logic [7:0]  tol;
  } exp_t;

  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam int LAT_FULL = 5 * (1 + 1 + 48 + 1 + 4) + 1;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  mat_t last_inv = '0;

  rrefs #(.FRAC(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .singular(singular),
    .inv11(inv[0]),  .inv12(inv[1]),  .inv13(inv[2]),  .inv14(inv[3]),  .inv15(inv[4]),
    .inv21(inv[5]),  .inv22(inv[6]),  .inv23(inv[7]),  .inv24(inv[8]),  .inv25(inv[9]),
    .inv31(inv[10]), .inv32(inv[11]), .inv33(inv[12]), .inv34(inv[13]), .inv35(inv[14]),
    .inv41(inv[15]), .inv42(inv[16]), .inv43(inv[17]), .inv44(inv[18]), .inv45(inv[19]),
    .inv51(inv[20]), .inv52(inv[21]), .inv53(inv[22]), .inv54(inv[23]), .inv55(inv[24])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                     input int tol);
    int d;
    n_vec++;
    d = int'($signed(obs - exp));
    if (d > tol || d < -tol) begin
      n_err++;
      $display("FAIL %s: got %h want %h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0, 0);
    chk({tag, "_done"}, 32'(done), 32'd0, 0);
    chk({tag, "_sing"}, 32'(singular), 32'd0, 0);
    for (int i = 0; i < 25; i++)
      chk($sformatf("%s_inv%0d%0d", tag, i / 5 + 1, i % 5 + 1), inv[i], 32'd0, 0);
  endtask

  task automatic load(input mat_t a);
    for (int i = 0; i < 25; i++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_data = a[i];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  // Push expectation, pulse start, wait (bounded) for done, then pop and compare.
  task automatic run(input string tag, input mat_t exp_inv, input logic exp_sing,
                     input int tol, input int exp_lat, input bit disturb);
    exp_t e;
    exp_t got;
    int   lat;
    bit   seen;
    e.inv  = exp_sing ? last_inv : exp_inv;
    e.sing = exp_sing;
    e.lat  = 16'(exp_lat);
    e.tol  = 8'(tol);
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1, 0);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      if (disturb && c == 5) begin
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0005_0000; start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    wr_en = 1'b0;
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1, 0);
    got = sb.pop_front();
    chk({tag, "_lat"}, 32'(lat), 32'(got.lat), 0);
    chk({tag, "_sing"}, 32'(singular), 32'(got.sing), 0);
    for (int i = 0; i < 25; i++)
      chk($sformatf("%s_inv%0d%0d", tag, i / 5 + 1, i % 5 + 1), inv[i], got.inv[i],
          int'(got.tol));
    if (!got.sing) last_inv = got.inv;
    @(posedge clk); #1;
    chk({tag, "_idle"}, 32'(busy), 32'd0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mat_t a_id, a_diag, e_diag, a_perm, e_perm, a_sing, a_j, e_j;
    a_id = '0; a_diag = '0; e_diag = '0; a_perm = '0; e_perm = '0; a_j = '0; e_j = '0;
    for (int i = 0; i < 5; i++) a_id[i*6] = ONE;
    a_diag[0] = 32'h0002_0000; e_diag[0] = 32'h0000_8000;
    a_diag[6] = 32'h0004_0000; e_diag[6] = 32'h0000_4000;
    a_diag[12] = 32'h0008_0000; e_diag[12] = 32'h0000_2000;
    a_diag[18] = 32'h0000_8000; e_diag[18] = 32'h0002_0000;
    a_diag[24] = 32'h0001_0000; e_diag[24] = 32'h0001_0000;
    a_perm[1] = ONE; a_perm[7] = ONE; a_perm[13] = ONE; a_perm[19] = ONE; a_perm[20] = ONE;
    e_perm[5] = ONE; e_perm[11] = ONE; e_perm[17] = ONE; e_perm[23] = ONE; e_perm[4] = ONE;
    a_sing = a_id;
    a_sing[12] = '0;
    for (int i = 0; i < 25; i++) begin
      a_j[i] = (i % 6 == 0) ? 32'h0002_0000 : ONE;
      e_j[i] = (i % 6 == 0) ? 32'h0000_D555 : 32'hFFFF_D555;
    end

    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    load(a_id);
    run("ident", a_id, 1'b0, 0, LAT_FULL, 1'b0);
    load(a_diag);
    run("diag", e_diag, 1'b0, 0, LAT_FULL, 1'b0);
    load(a_perm);
    run("perm", e_perm, 1'b0, 0, LAT_FULL, 1'b0);
    load(a_sing);
    run("sing", '0, 1'b1, 0, 2 * 55 + 2, 1'b0);
    load(a_j);
    run("ones", e_j, 1'b0, 2, LAT_FULL, 1'b0);

    // Abort during the first reciprocal.
    load(a_diag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    last_inv = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset cleared the A store: a zero matrix is singular at the first pivot.
    run("zeroA", '0, 1'b1, 0, 2, 1'b0);
    load(a_diag);
    run("rerun", e_diag, 1'b0, 0, LAT_FULL, 1'b0);

    load(a_perm);
    run("busywr", e_perm, 1'b0, 0, LAT_FULL, 1'b1);
    run("again", e_perm, 1'b0, 0, LAT_FULL, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rrefs.md
Name:
rrefs

Overview:
- 5x5 matrix inverter using Gauss-Jordan reduction to reduced row-echelon form on the augmented matrix [A | I].
- Signed Q16.16 fixed point throughout.
- Host writes A element by element, pulses start, and waits for done. The result appears on 25 parallel 32-bit outputs inv11..inv55.
- Sits as a memory-mapped linear-algebra accelerator beside the processor datapath.

Parameters:
- FRAC, 16, fractional bits of the Q format (word width fixed at 32).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write one element of A
- wr_addr  in  5  element index, row-major: 0=a11 .. 24=a55; 25..31 ignored
- wr_data  in  32  element value, signed Q16.16
- start  in  1  one-cycle pulse, begins inversion
- busy  out  1  high while inverting
- done  out  1  one-cycle pulse at completion
- singular  out  1  high if last run found A singular; cleared by next start
- inv11..inv55  out  32 each  inverse element (row,col), signed Q16.16

Behaviour:
- Reset (async, rst_n=0):
  - A store, working matrices, all inv outputs, busy, done and singular = 0.
  - FSM goes to IDLE.
- Load:
  - In IDLE, wr_en writes wr_data to A[wr_addr] at the clock edge.
  - Writes while busy are ignored. A store is not modified by inversion.
- start in IDLE:
  - Copies A into working matrix M and sets augmented W=I (1.0 = 0x00010000).
  - busy=1, singular=0, k=0.
  - start while busy is ignored.
- FSM: IDLE -> PIVOT -> SWAP -> RECIP -> NORM -> ELIM -> (k<4 ? PIVOT with k+1 : FINISH) -> IDLE.
- PIVOT (1 cycle):
  - Selects row p in k..4 with largest |M[p][k]|; ties go to the lowest index.
  - If that magnitude is 0, go to FINISH with singular=1.
- SWAP (1 cycle): exchanges rows p and k of both M and W; no-op if p=k.
- RECIP:
  - Sequential restoring divider computes r = (1<<32) / M[k][k], signed and truncated toward zero.
  - Divides magnitudes, fixes sign after; 1 quotient bit per cycle, 48 cycles.
- NORM (1 cycle):
  - Every element x of row k in M and W becomes (x*r)>>>16, using a 64-bit product with arithmetic shift.
  - Then M[k][k] is forced to exactly 0x00010000.
- ELIM (4 cycles, one row i != k per cycle, ascending i):
  - f = M[i][k]; each element in row i of M and W becomes x - ((f*rowk_x)>>>16).
  - Then M[i][k] is forced to 0.
- Arithmetic:
  - 32-bit results wrap on overflow; no saturation.
  - Products are 64-bit signed.
- FINISH (1 cycle):
  - If not singular, inv(i,j) <= W[i][j].
  - If singular, inv outputs keep their previous values.
  - done=1 for exactly this cycle; busy=0 next cycle.
- Latency: start edge to done pulse is fixed at 5*(1+1+48+1+4)+1 = 276 cycles for a nonsingular A. It is shorter when singular.
- Outputs are registered. They change only in FINISH or reset.
- Reset mid-operation aborts immediately and clears everything as above.

Test Plan:
- Reset, load identity, start -> done after 276 cycles; inv(i,i)=0x00010000, off-diagonal 0; singular=0.
- A=diag(2,4,8,0.5,1) (0x00020000, 0x00040000, 0x00080000, 0x00008000, 0x00010000) -> inv diag 0x00008000, 0x00004000, 0x00002000, 0x00020000, 0x00010000.
- A = permutation with a12=a23=a34=a45=a51=1.0 (forces row swaps) -> inv = transpose: inv21=inv32=inv43=inv54=inv15=0x00010000, rest 0.
- A with row 3 all zero -> done pulse, singular=1, inv outputs unchanged from previous run.
- Full matrix a_ij=1.0 except a_ii=2.0 -> inv_ii approx 5/6 (0x0000D555 +-2 LSB), off-diagonal approx -1/6 (0xFFFFD555 +-2 LSB).
- Assert rst_n low mid-RECIP -> busy, done, singular and all inv outputs 0 immediately.
- Re-run after reset -> correct result.
- wr_en and a second start while busy -> ignored; result equals that of the original A.
